// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: pattern type, hex glyph constants, symbol kinds and
// the decoder's handshake states.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Active-high segments, bit0=a .. bit6=g.
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    KIND_DIGIT   = 2'd0,
    KIND_BLANK   = 2'd1,
    KIND_INVALID = 2'd2
  } kind_t;

  typedef enum logic {
    StTrack,
    StPresent
  } state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational segment-pattern to symbol lookup; also usable as a reference model
// for the encoder.
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  seg_t        seg_i,
  output kind_t       kind_o,
  output logic [3:0]  nibble_o
);

  always_comb begin
    kind_o   = KIND_DIGIT;
    nibble_o = 4'h0;
    case (seg_i)
      SEG_0:     nibble_o = 4'h0;
      SEG_1:     nibble_o = 4'h1;
      SEG_2:     nibble_o = 4'h2;
      SEG_3:     nibble_o = 4'h3;
      SEG_4:     nibble_o = 4'h4;
      SEG_5:     nibble_o = 4'h5;
      SEG_6:     nibble_o = 4'h6;
      SEG_7:     nibble_o = 4'h7;
      SEG_8:     nibble_o = 4'h8;
      SEG_9:     nibble_o = 4'h9;
      SEG_A:     nibble_o = 4'hA;
      SEG_B:     nibble_o = 4'hB;
      SEG_C:     nibble_o = 4'hC;
      SEG_D:     nibble_o = 4'hD;
      SEG_E:     nibble_o = 4'hE;
      SEG_F:     nibble_o = 4'hF;
      SEG_BLANK: kind_o   = KIND_BLANK;
      default:   kind_o   = KIND_INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Debounces a 7-segment pattern, decodes each newly stable pattern and presents it
// once over a valid/ready handshake, flagging symbols dropped while stalled.
module seg7_pattern_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [6:0]       seg_in,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic             out_valid,
  output logic [3:0]       out_data,
  output logic [1:0]       out_kind,
  output logic             overrun,
  output logic [CNT_W-1:0] sym_count
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  seg_t             seg_q, cand_q, cand_d, last_acc_q, last_acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, sym_count_q, sym_count_d;
  logic [3:0]       out_data_q, out_data_d;
  kind_t            out_kind_q, out_kind_d;
  logic             overrun_q, overrun_d;
  state_t           state_q, state_d;
  logic             qualify;
  kind_t            lut_kind;
  logic [3:0]       lut_nibble;

  seg7_pattern_lookup u_lookup (
    .seg_i    (cand_q),
    .kind_o   (lut_kind),
    .nibble_o (lut_nibble)
  );

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (seg_q != cand_q) begin
      cand_d = seg_q;
      cnt_d  = '0;
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Once accepted, last_acc equals cand, so each stable run qualifies at most once.
  assign qualify    = (cand_q == seg_q) && (cnt_q == CntMax) && (cand_q != last_acc_q);
  assign last_acc_d = qualify ? cand_q : last_acc_q;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_kind_d  = out_kind_q;
    sym_count_d = sym_count_q;
    overrun_d   = ovr_clr ? 1'b0 : overrun_q;
    unique case (state_q)
      StTrack: begin
        if (qualify) begin
          out_data_d = lut_nibble;
          out_kind_d = lut_kind;
          state_d    = StPresent;
        end
      end
      StPresent: begin
        if (out_ready) begin
          sym_count_d = sym_count_q + 1'b1;
          if (qualify) begin
            out_data_d = lut_nibble;
            out_kind_d = lut_kind;
          end else begin
            state_d = StTrack;
          end
        end else if (qualify) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = StTrack;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      seg_q       <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      last_acc_q  <= SEG_BLANK;
      state_q     <= StTrack;
      out_data_q  <= '0;
      out_kind_q  <= KIND_DIGIT;
      overrun_q   <= 1'b0;
      sym_count_q <= '0;
    end else begin
      seg_q       <= seg_in;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      last_acc_q  <= last_acc_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_kind_q  <= out_kind_d;
      overrun_q   <= overrun_d;
      sym_count_q <= sym_count_d;
    end
  end

  assign out_valid = (state_q == StPresent);
  assign out_data  = out_data_q;
  assign out_kind  = out_kind_q;
  assign overrun   = overrun_q;
  assign sym_count = sym_count_q;

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Scoreboard bench for seg7_pattern_decoder: directed patterns push expected symbols,
// a negedge monitor pops and compares each completed handshake.
module tb_seg7_pattern_decoder;

  logic       clk_2 = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] seg_in = 7'h00;
  logic       out_ready = 1'b1;
  logic       ovr_clr = 1'b0;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_kind;
  logic       overrun;
  logic [7:0] sym_count;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];  // {kind, nibble}

  seg7_pattern_decoder #(
    .STABLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk_2     (clk_2),
    .reset_n   (reset_n),
    .seg_in    (seg_in),
    .out_ready (out_ready),
    .ovr_clr   (ovr_clr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_kind  (out_kind),
    .overrun   (overrun),
    .sym_count (sym_count)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic deliver(input logic [6:0] pat, input logic [1:0] kind, input logic [3:0] nib);
    seg_in = pat;
    exp_q.push_back({kind, nib});
    repeat (8) tick();
  endtask

  // Monitor: a handshake completes at the next rising edge when valid and ready are high.
  always @(negedge clk_2) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_symbol: got kind %0d data %0h, expected none",
                 out_kind, out_data);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if ({out_kind, out_data} !== e) begin
          errors++;
          $display("FAIL symbol: got kind %0d data %0h, expected kind %0d data %0h",
                   out_kind, out_data, e[5:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    int edges;
    bit seen;

    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_kind", out_kind, 0);
    check("rst_overrun", overrun, 0);
    check("rst_count", sym_count, 0);
    repeat (2) @(posedge clk_2);
    #1 reset_n = 1'b1;
    tick();

    // Short glitch, then back to blank (already last accepted): nothing delivered.
    seg_in = 7'h06;
    repeat (3) tick();
    seg_in = 7'h00;
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("glitch_no_valid", int'(seen), 0);
    check("glitch_count", sym_count, 0);

    // Latency: valid on the 6th edge after the change.
    seg_in = 7'h5B;
    exp_q.push_back({2'd0, 4'h2});
    edges = 0;
    do begin
      @(posedge clk_2);
      edges++;
      #1;
    end while (!out_valid && edges < 20);
    check("latency_edges", edges, 6);
    tick();
    check("count_after_first", sym_count, 1);

    // Digit then invalid.
    seg_in = 7'h77;
    exp_q.push_back({2'd0, 4'hA});
    repeat (10) tick();
    seg_in = 7'h12;
    exp_q.push_back({2'd2, 4'h0});
    repeat (10) tick();
    check("count_after_invalid", sym_count, 3);

    // Stall with a new pattern arriving: drop and overrun.
    out_ready = 1'b0;
    seg_in = 7'h4F;
    exp_q.push_back({2'd0, 4'h3});
    edges = 0;
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
    check("stall_valid", out_valid, 1);
    seg_in = 7'h66;
    repeat (10) tick();
    check("stall_data_held", out_data, 3);
    check("overrun_set", overrun, 1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("overrun_cleared", overrun, 0);
    check("stall_count", sym_count, 3);

    // Ready rises in the same cycle 7F qualifies: back-to-back reload.
    seg_in = 7'h7F;
    exp_q.push_back({2'd0, 4'h8});
    repeat (5) tick();
    out_ready = 1'b1;
    tick();
    check("b2b_valid", out_valid, 1);
    check("b2b_data", out_data, 8);
    check("b2b_overrun", overrun, 0);
    check("b2b_count", sym_count, 4);
    tick();
    check("b2b_count_done", sym_count, 5);

    // Preload to 255 deliveries, then wrap.
    for (int i = 0; i < 250; i++) begin
      if (i % 2 == 0) deliver(7'h3F, 2'd0, 4'h0);
      else            deliver(7'h06, 2'd0, 4'h1);
    end
    check("count_255", sym_count, 255);
    deliver(7'h5B, 2'd0, 4'h2);
    check("count_wrap", sym_count, 0);

    // Present a blank under stall, then reset mid-handshake.
    out_ready = 1'b0;
    seg_in = 7'h00;
    repeat (8) tick();
    check("blank_valid", out_valid, 1);
    check("blank_kind", out_kind, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_count", sym_count, 0);
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("no_blank_reemit", int'(seen), 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
